// File: rtl/ti170_pkg.sv
// rtl/ti170_pkg.sv - TI170 control encodings: opcodes, bus/ALU selects, states, strobe bundle
package ti170_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_INC = 3'b100;
    localparam logic [2:0] ALU_DEC = 3'b101;

    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    // Execute states are split per destination so every strobe is a pure function of state.
    typedef enum logic [4:0] {
        S_RST, S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE, S_WAIT,
        S_OPA_0, S_OPA_1, S_MAR_MEM, S_RD_IDLE,
        S_LDA_MEM, S_LDB_MEM, S_STA, S_STB, S_PC_MEM, S_BR_SKIP,
        S_ADD_AB, S_SUB_AB, S_AND_AB, S_OR_AB, S_INCA, S_INCB, S_DECA, S_DECB
    } state_t;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic       ccr_load;
        logic       write;
        logic [2:0] alu_sel;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
    } ctrl_t;

endpackage

// File: rtl/ccr_cond_eval.sv
// rtl/ccr_cond_eval.sv - branch opcode recognition and NZVC condition evaluation
module ccr_cond_eval
    import ti170_pkg::*;
#(
    parameter int OPC_W = 8,
    parameter int CCR_W = 4
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [CCR_W-1:0] ccr,
    output logic             is_branch,
    output logic             branch_taken
);

    always_comb begin
        is_branch    = 1'b1;
        branch_taken = 1'b0;
        case (opcode)
            OPC_W'(OP_BRA): branch_taken = 1'b1;
            OPC_W'(OP_BMI): branch_taken = ccr[CCR_N];
            OPC_W'(OP_BPL): branch_taken = !ccr[CCR_N];
            OPC_W'(OP_BEQ): branch_taken = ccr[CCR_Z];
            OPC_W'(OP_BNE): branch_taken = !ccr[CCR_Z];
            OPC_W'(OP_BVS): branch_taken = ccr[CCR_V];
            OPC_W'(OP_BVC): branch_taken = !ccr[CCR_V];
            OPC_W'(OP_BCS): branch_taken = ccr[CCR_C];
            OPC_W'(OP_BCC): branch_taken = !ccr[CCR_C];
            default:        is_branch    = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_gen.sv
// rtl/control_unit_gen.sv - TI170 Moore control FSM with memory-read wait states
module control_unit_gen
    import ti170_pkg::*;
#(
    parameter int OPC_W     = 8,
    parameter int CCR_W     = 4,
    parameter int ALU_SEL_W = 3,
    parameter int RD_WAIT   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OPC_W-1:0]     IR,
    input  logic [CCR_W-1:0]     CCR_Result,
    output logic                 IR_Load,
    output logic                 MAR_Load,
    output logic                 PC_Load,
    output logic                 PC_Inc,
    output logic                 A_Load,
    output logic                 B_Load,
    output logic                 CCR_Load,
    output logic                 write,
    output logic [ALU_SEL_W-1:0] ALU_Sel,
    output logic [1:0]           Bus1_Sel,
    output logic [1:0]           Bus2_Sel,
    output logic                 illegal_op,
    output logic [4:0]           state_dbg
);

    localparam logic [3:0] WAIT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t     state, state_next, ret_state, rd_target;
    logic [3:0] wait_cnt;
    logic       rd_handoff, set_illegal;
    logic       is_branch, branch_taken;
    ctrl_t      ctrl;

    ccr_cond_eval #(.OPC_W(OPC_W), .CCR_W(CCR_W)) u_cond (
        .opcode       (IR),
        .ccr          (CCR_Result),
        .is_branch    (is_branch),
        .branch_taken (branch_taken)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_RST;
            ret_state  <= S_RST;
            wait_cnt   <= 4'd0;
            illegal_op <= 1'b0;
        end else begin
            state <= state_next;
            if (rd_handoff) begin
                ret_state <= rd_target;
                wait_cnt  <= WAIT_INIT;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (set_illegal) illegal_op <= 1'b1;
        end
    end

    // rd_handoff marks the cycle after a read address was presented; the data
    // consumer (rd_target) is reached either directly or through S_WAIT.
    always_comb begin
        state_next  = state;
        rd_handoff  = 1'b0;
        rd_target   = S_FETCH_0;
        set_illegal = 1'b0;
        case (state)
            S_RST:     state_next = S_FETCH_0;
            S_FETCH_0: state_next = S_FETCH_1;
            S_FETCH_1: begin
                rd_handoff = 1'b1;
                rd_target  = S_FETCH_2;
            end
            S_FETCH_2: state_next = S_DECODE;
            S_DECODE: begin
                case (IR)
                    OPC_W'(OP_LDA_IMM), OPC_W'(OP_LDA_DIR), OPC_W'(OP_LDB_IMM),
                    OPC_W'(OP_LDB_DIR), OPC_W'(OP_STA_DIR), OPC_W'(OP_STB_DIR):
                                       state_next = S_OPA_0;
                    OPC_W'(OP_ADD_AB): state_next = S_ADD_AB;
                    OPC_W'(OP_SUB_AB): state_next = S_SUB_AB;
                    OPC_W'(OP_AND_AB): state_next = S_AND_AB;
                    OPC_W'(OP_OR_AB):  state_next = S_OR_AB;
                    OPC_W'(OP_INCA):   state_next = S_INCA;
                    OPC_W'(OP_INCB):   state_next = S_INCB;
                    OPC_W'(OP_DECA):   state_next = S_DECA;
                    OPC_W'(OP_DECB):   state_next = S_DECB;
                    default: begin
                        if (is_branch) begin
                            state_next = branch_taken ? S_OPA_0 : S_BR_SKIP;
                        end else begin
                            state_next  = S_FETCH_0;
                            set_illegal = 1'b1;
                        end
                    end
                endcase
            end
            S_WAIT:    if (wait_cnt == 4'd0) state_next = ret_state;
            S_OPA_0:   state_next = is_branch ? S_RD_IDLE : S_OPA_1;
            S_OPA_1: begin
                rd_handoff = 1'b1;
                if (IR == OPC_W'(OP_LDA_IMM))      rd_target = S_LDA_MEM;
                else if (IR == OPC_W'(OP_LDB_IMM)) rd_target = S_LDB_MEM;
                else                               rd_target = S_MAR_MEM;
            end
            S_MAR_MEM: begin
                if (IR == OPC_W'(OP_STA_DIR))      state_next = S_STA;
                else if (IR == OPC_W'(OP_STB_DIR)) state_next = S_STB;
                else                               state_next = S_RD_IDLE;
            end
            S_RD_IDLE: begin
                rd_handoff = 1'b1;
                if (is_branch)                     rd_target = S_PC_MEM;
                else if (IR == OPC_W'(OP_LDA_DIR)) rd_target = S_LDA_MEM;
                else                               rd_target = S_LDB_MEM;
            end
            default:   state_next = S_FETCH_0;
        endcase
        if (rd_handoff) state_next = (RD_WAIT == 0) ? rd_target : S_WAIT;
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH_0, S_OPA_0: begin
                ctrl.mar_load = 1'b1;
                ctrl.bus1_sel = BUS1_PC;
                ctrl.bus2_sel = BUS2_BUS1;
            end
            S_FETCH_1, S_OPA_1, S_BR_SKIP: ctrl.pc_inc = 1'b1;
            S_FETCH_2: begin
                ctrl.ir_load  = 1'b1;
                ctrl.bus2_sel = BUS2_MEM;
            end
            S_MAR_MEM: begin
                ctrl.mar_load = 1'b1;
                ctrl.bus2_sel = BUS2_MEM;
            end
            S_LDA_MEM: begin
                ctrl.a_load   = 1'b1;
                ctrl.bus2_sel = BUS2_MEM;
            end
            S_LDB_MEM: begin
                ctrl.b_load   = 1'b1;
                ctrl.bus2_sel = BUS2_MEM;
            end
            S_STA: begin
                ctrl.write    = 1'b1;
                ctrl.bus1_sel = BUS1_A;
            end
            S_STB: begin
                ctrl.write    = 1'b1;
                ctrl.bus1_sel = BUS1_B;
            end
            S_PC_MEM: begin
                ctrl.pc_load  = 1'b1;
                ctrl.bus2_sel = BUS2_MEM;
            end
            S_ADD_AB, S_SUB_AB, S_AND_AB, S_OR_AB, S_INCA, S_DECA: begin
                ctrl.bus1_sel = BUS1_A;
                ctrl.bus2_sel = BUS2_ALU;
                ctrl.a_load   = 1'b1;
                ctrl.ccr_load = 1'b1;
                case (state)
                    S_SUB_AB: ctrl.alu_sel = ALU_SUB;
                    S_AND_AB: ctrl.alu_sel = ALU_AND;
                    S_OR_AB:  ctrl.alu_sel = ALU_OR;
                    S_INCA:   ctrl.alu_sel = ALU_INC;
                    S_DECA:   ctrl.alu_sel = ALU_DEC;
                    default:  ctrl.alu_sel = ALU_ADD;
                endcase
            end
            S_INCB, S_DECB: begin
                ctrl.bus1_sel = BUS1_B;
                ctrl.bus2_sel = BUS2_ALU;
                ctrl.b_load   = 1'b1;
                ctrl.ccr_load = 1'b1;
                ctrl.alu_sel  = (state == S_INCB) ? ALU_INC : ALU_DEC;
            end
            default: ctrl = '0;
        endcase
    end

    assign IR_Load   = ctrl.ir_load;
    assign MAR_Load  = ctrl.mar_load;
    assign PC_Load   = ctrl.pc_load;
    assign PC_Inc    = ctrl.pc_inc;
    assign A_Load    = ctrl.a_load;
    assign B_Load    = ctrl.b_load;
    assign CCR_Load  = ctrl.ccr_load;
    assign write     = ctrl.write;
    assign ALU_Sel   = ALU_SEL_W'(ctrl.alu_sel);
    assign Bus1_Sel  = ctrl.bus1_sel;
    assign Bus2_Sel  = ctrl.bus2_sel;
    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit_gen.sv
// tb/tb_control_unit_gen.sv - table-driven scoreboard bench for control_unit_gen at RD_WAIT 0 and 2
module tb_control_unit_gen;
    import ti170_pkg::*;

    // Strobe word: {IR_Load,MAR_Load,PC_Load,PC_Inc,A_Load,B_Load,CCR_Load,write,ALU_Sel,Bus1,Bus2}
    localparam logic [14:0] B_IRL  = 15'h4000;
    localparam logic [14:0] B_MARL = 15'h2000;
    localparam logic [14:0] B_PCL  = 15'h1000;
    localparam logic [14:0] B_PCI  = 15'h0800;
    localparam logic [14:0] B_AL   = 15'h0400;
    localparam logic [14:0] B_BL   = 15'h0200;
    localparam logic [14:0] B_CCRL = 15'h0100;
    localparam logic [14:0] B_WR   = 15'h0080;
    localparam logic [14:0] W_IDLE   = 15'h0000;
    localparam logic [14:0] W_MARPC  = B_MARL | 15'd1;
    localparam logic [14:0] W_PCINC  = B_PCI;
    localparam logic [14:0] W_IRLD   = B_IRL | 15'd2;
    localparam logic [14:0] W_LDA    = B_AL | 15'd2;
    localparam logic [14:0] W_LDB    = B_BL | 15'd2;
    localparam logic [14:0] W_MARMEM = B_MARL | 15'd2;
    localparam logic [14:0] W_STA    = B_WR | 15'd4;
    localparam logic [14:0] W_STB    = B_WR | 15'd8;
    localparam logic [14:0] W_PCMEM  = B_PCL | 15'd2;

    typedef struct packed {
        logic [7:0]       op;
        logic [3:0]       ccr;
        logic [3:0]       ccr_late;
        logic [2:0]       n;
        logic [4:0]       wmask;
        logic [4:0][14:0] ex;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [7:0] IR = 8'h00;
    logic [3:0] CCR = 4'h0;
    logic sel = 1'b0;

    logic ir_l0, mar_l0, pc_l0, pc_i0, a_l0, b_l0, ccr_l0, wr0, ill0;
    logic ir_l2, mar_l2, pc_l2, pc_i2, a_l2, b_l2, ccr_l2, wr2, ill2;
    logic [2:0] alu0, alu2;
    logic [1:0] b1_0, b2_0, b1_2, b2_2;
    logic [4:0] sd0, sd2;
    logic [14:0] outw0, outw2, outw;
    logic [4:0] sdbg;
    logic ill;

    int n_cmp = 0;
    int n_bad = 0;
    logic seen_ill;
    vec_t vecs[$];
    logic [14:0] exp_q[$];

    always #5 clock = ~clock;

    control_unit_gen #(.OPC_W(8), .CCR_W(4), .ALU_SEL_W(3), .RD_WAIT(0)) dut0 (
        .clock(clock), .reset(reset), .IR(IR), .CCR_Result(CCR),
        .IR_Load(ir_l0), .MAR_Load(mar_l0), .PC_Load(pc_l0), .PC_Inc(pc_i0),
        .A_Load(a_l0), .B_Load(b_l0), .CCR_Load(ccr_l0), .write(wr0),
        .ALU_Sel(alu0), .Bus1_Sel(b1_0), .Bus2_Sel(b2_0),
        .illegal_op(ill0), .state_dbg(sd0)
    );

    control_unit_gen #(.OPC_W(8), .CCR_W(4), .ALU_SEL_W(3), .RD_WAIT(2)) dut2 (
        .clock(clock), .reset(reset), .IR(IR), .CCR_Result(CCR),
        .IR_Load(ir_l2), .MAR_Load(mar_l2), .PC_Load(pc_l2), .PC_Inc(pc_i2),
        .A_Load(a_l2), .B_Load(b_l2), .CCR_Load(ccr_l2), .write(wr2),
        .ALU_Sel(alu2), .Bus1_Sel(b1_2), .Bus2_Sel(b2_2),
        .illegal_op(ill2), .state_dbg(sd2)
    );

    assign outw0 = {ir_l0, mar_l0, pc_l0, pc_i0, a_l0, b_l0, ccr_l0, wr0, alu0, b1_0, b2_0};
    assign outw2 = {ir_l2, mar_l2, pc_l2, pc_i2, a_l2, b_l2, ccr_l2, wr2, alu2, b1_2, b2_2};
    assign outw  = sel ? outw2 : outw0;
    assign sdbg  = sel ? sd2 : sd0;
    assign ill   = sel ? ill2 : ill0;

    task automatic check(input string tag, input int idx, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] dut%0d: got %h expected %h", tag, idx, sel ? 2 : 0, act, exp);
        end
    endtask

    function automatic logic [14:0] alu_w(input logic [2:0] s, input logic dest_b);
        return B_CCRL | (dest_b ? B_BL : B_AL) | {8'd0, s, dest_b ? 2'b10 : 2'b01, 2'b00};
    endfunction

    function automatic vec_t mk(input logic [7:0] op, input logic [3:0] ccr, input logic [3:0] late,
                                input int n, input logic [4:0] wm,
                                input logic [14:0] e0 = 15'd0, input logic [14:0] e1 = 15'd0,
                                input logic [14:0] e2 = 15'd0, input logic [14:0] e3 = 15'd0,
                                input logic [14:0] e4 = 15'd0);
        vec_t v;
        v.op = op; v.ccr = ccr; v.ccr_late = late; v.n = 3'(n); v.wmask = wm;
        v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3; v.ex[4] = e4;
        return v;
    endfunction

    // Expected per-cycle strobes are queued up front, then popped one per cycle.
    task automatic run_vec(input int k, input vec_t v, input int w);
        exp_q.delete();
        exp_q.push_back(W_MARPC);
        exp_q.push_back(W_PCINC);
        repeat (w) exp_q.push_back(W_IDLE);
        exp_q.push_back(W_IRLD);
        exp_q.push_back(W_IDLE);
        for (int i = 0; i < int'(v.n); i++) begin
            exp_q.push_back(v.ex[i]);
            if (v.wmask[i]) repeat (w) exp_q.push_back(W_IDLE);
        end
        IR  = v.op;
        CCR = v.ccr;
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 4 + w) CCR = v.ccr_late;
            check("strobe", k * 100 + c, outw, exp_q.pop_front());
            @(negedge clock);
        end
        if (v.op == 8'hFF) seen_ill = 1'b1;
        check("end_state", k, 15'(sdbg), 15'(S_FETCH_0));
        check("illegal_op", k, 15'(ill), 15'(seen_ill));
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check("rst_state", 0, 15'(sdbg), 15'(S_RST));
        check("rst_out", 0, outw, W_IDLE);
        check("rst_ill", 0, 15'(ill), 15'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen_ill = 1'b0;
        #1;
        check("rel_state", 0, 15'(sdbg), 15'(S_RST));
        check("rel_out", 0, outw, W_IDLE);
        @(negedge clock);
    endtask

    initial begin
        seen_ill = 1'b0;
        vecs.push_back(mk(8'h86, 4'h0, 4'h0, 3, 5'b00010, W_MARPC, W_PCINC, W_LDA));
        vecs.push_back(mk(8'h88, 4'h0, 4'h0, 3, 5'b00010, W_MARPC, W_PCINC, W_LDB));
        vecs.push_back(mk(8'h87, 4'h0, 4'h0, 5, 5'b01010, W_MARPC, W_PCINC, W_MARMEM, W_IDLE, W_LDA));
        vecs.push_back(mk(8'h89, 4'h0, 4'h0, 5, 5'b01010, W_MARPC, W_PCINC, W_MARMEM, W_IDLE, W_LDB));
        vecs.push_back(mk(8'h96, 4'h0, 4'h0, 4, 5'b00010, W_MARPC, W_PCINC, W_MARMEM, W_STA));
        vecs.push_back(mk(8'h97, 4'h0, 4'h0, 4, 5'b00010, W_MARPC, W_PCINC, W_MARMEM, W_STB));
        vecs.push_back(mk(8'h42, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b000, 1'b0)));
        vecs.push_back(mk(8'h43, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b001, 1'b0)));
        vecs.push_back(mk(8'h44, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b010, 1'b0)));
        vecs.push_back(mk(8'h45, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b011, 1'b0)));
        vecs.push_back(mk(8'h46, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b100, 1'b0)));
        vecs.push_back(mk(8'h47, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b100, 1'b1)));
        vecs.push_back(mk(8'h48, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b101, 1'b0)));
        vecs.push_back(mk(8'h49, 4'h0, 4'h0, 1, 5'b0, alu_w(3'b101, 1'b1)));
        vecs.push_back(mk(8'hFF, 4'hF, 4'hF, 0, 5'b0));
        vecs.push_back(mk(8'h20, 4'h0, 4'h0, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h23, 4'h4, 4'h4, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h23, 4'h0, 4'h0, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h24, 4'h0, 4'h0, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h24, 4'h4, 4'h4, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h21, 4'h8, 4'h8, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h22, 4'h8, 4'h8, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h25, 4'h2, 4'h2, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h26, 4'h2, 4'h2, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h27, 4'h1, 4'h1, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h28, 4'h1, 4'h1, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h28, 4'hE, 4'hE, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h23, 4'h0, 4'h4, 1, 5'b0, W_PCINC));
        vecs.push_back(mk(8'h23, 4'h4, 4'h0, 3, 5'b00010, W_MARPC, W_IDLE, W_PCMEM));
        vecs.push_back(mk(8'h86, 4'h0, 4'h0, 3, 5'b00010, W_MARPC, W_PCINC, W_LDA));

        @(negedge clock);
        sel = 1'b0;
        reset_pulse();
        foreach (vecs[k]) run_vec(k, vecs[k], 0);

        // Reset asserted in the middle of an LDA_DIR execute phase.
        IR = 8'h87;
        repeat (6) @(negedge clock);
        check("mid_pre_ill", 0, 15'(ill), 15'd1);
        check("mid_pre_state", 0, 15'(sdbg), 15'(S_MAR_MEM));
        reset_pulse();
        run_vec(50, vecs[2], 0);

        sel = 1'b1;
        reset_pulse();
        foreach (vecs[k]) run_vec(100 + k, vecs[k], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
